core_lsu: RTL and testbench

CORE_LSU -- requirements
Module: core_lsu

---
 rtl/core_pkg.sv | 42 ++++
 rtl/core_lsu_align.sv | 44 ++++
 rtl/core_lsu.sv | 163 ++++++++++++++++
 tb/tb_core_lsu.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the load/store unit.
package core_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    MISALIGNED  = 2'd1,
    BUS_TIMEOUT = 2'd2
  } lsu_exc_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_off_mask(lsu_size_e s);
    case (s)
      SIZE_BYTE: return 3'b000;
      SIZE_HALF: return 3'b001;
      SIZE_WORD: return 3'b011;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_be_mask(lsu_size_e s);
    case (s)
      SIZE_BYTE: return 8'h01;
      SIZE_HALF: return 8'h03;
      SIZE_WORD: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane steering: store byte enables / data shift, load shift and extension.
module core_lsu_align
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  lsu_size_e               st_size,
  input  logic [LANE_W-1:0]       st_lane,
  input  logic [XLEN-1:0]         wdata,
  input  lsu_size_e               ld_size,
  input  logic [LANE_W-1:0]       ld_lane,
  input  logic                    ld_unsigned,
  input  logic [XLEN-1:0]         rdata,
  output logic [XLEN/8-1:0]       be,
  output logic [XLEN-1:0]         wdata_sh,
  output logic [XLEN-1:0]         rdata_ext
);

  logic [XLEN-1:0] rdata_sh;

  always_comb begin
    be        = (XLEN/8)'(size_be_mask(st_size) << st_lane);
    wdata_sh  = wdata << {st_lane, 3'b000};
    rdata_sh  = rdata >> {ld_lane, 3'b000};
    rdata_ext = rdata_sh;
    case (ld_size)
      SIZE_BYTE: begin
        if (ld_unsigned) rdata_ext = XLEN'(rdata_sh[7:0]);
        else             rdata_ext = XLEN'($signed(rdata_sh[7:0]));
      end
      SIZE_HALF: begin
        if (ld_unsigned) rdata_ext = XLEN'(rdata_sh[15:0]);
        else             rdata_ext = XLEN'($signed(rdata_sh[15:0]));
      end
      SIZE_WORD: begin
        if (ld_unsigned) rdata_ext = XLEN'(rdata_sh[31:0]);
        else             rdata_ext = XLEN'($signed(rdata_sh[31:0]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one outstanding bus access, req/grant then rvalid, with bus timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned requests instead of aligning them down.
//   state | meaning
//   IDLE  | ready for a new request
//   REQ   | bus request held until grant
//   WAIT  | load granted, waiting for read data
module core_lsu
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_store_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  input  logic [4:0]          req_rd_i,
  output logic                wb_valid_o,
  output logic [4:0]          wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                exc_o,
  output logic [1:0]          exc_cause_o,
  output logic                data_mem_req_o,
  input  logic                data_mem_grnt_i,
  output logic [ADDR_W-1:0]   data_mem_addr_o,
  output logic [XLEN-1:0]     data_mem_wdata_o,
  output logic [XLEN/8-1:0]   data_mem_be_o,
  output logic                data_mem_wen_o,
  input  logic [XLEN-1:0]     data_mem_rdata_i,
  input  logic                data_mem_rvalid_i
);

  localparam int LB    = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             tc_hit;
  lsu_size_e        size_eff;
  logic [LB-1:0]    off_mask;
  logic [LB-1:0]    lane;
  lsu_size_e        ld_size;
  logic [LB-1:0]    ld_lane;
  logic             ld_unsigned;
  logic [4:0]       ld_rd;
  logic [XLEN/8-1:0] be_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  rdata_c;
`ifdef LSU_MISALIGN_TRAP_EN
  logic             misaligned;
`endif

  assign req_ready_o = (state == IDLE);
  // Counter saturates, so a load granted on the last budget cycle still gets one WAIT cycle.
  assign tc_hit = (TIMEOUT_CYC != 0) && (cnt >= TC_LAST);

  always_comb begin
    size_eff = lsu_size_e'(req_size_i);
    if (XLEN == 32 && size_eff == SIZE_DWORD) size_eff = SIZE_WORD;
    off_mask = LB'(size_off_mask(size_eff));
    lane     = req_addr_i[LB-1:0] & ~off_mask;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = |(req_addr_i[LB-1:0] & off_mask);
`endif
  end

  core_lsu_align #(.XLEN(XLEN), .LANE_W(LB)) u_align (
    .st_size     (size_eff),
    .st_lane     (lane),
    .wdata       (req_wdata_i),
    .ld_size     (ld_size),
    .ld_lane     (ld_lane),
    .ld_unsigned (ld_unsigned),
    .rdata       (data_mem_rdata_i),
    .be          (be_c),
    .wdata_sh    (wdata_c),
    .rdata_ext   (rdata_c)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state            <= IDLE;
      cnt              <= '0;
      data_mem_req_o   <= 1'b0;
      data_mem_addr_o  <= '0;
      data_mem_wdata_o <= '0;
      data_mem_be_o    <= '0;
      data_mem_wen_o   <= 1'b0;
      wb_valid_o       <= 1'b0;
      wb_rd_o          <= '0;
      wb_data_o        <= '0;
      exc_o            <= 1'b0;
      exc_cause_o      <= NONE;
      ld_size          <= SIZE_BYTE;
      ld_lane          <= '0;
      ld_unsigned      <= 1'b0;
      ld_rd            <= '0;
    end else begin
      wb_valid_o  <= 1'b0;
      exc_o       <= 1'b0;
      exc_cause_o <= NONE;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              exc_o       <= 1'b1;
              exc_cause_o <= MISALIGNED;
            end else
`endif
            begin
              state            <= REQ;
              cnt              <= '0;
              data_mem_req_o   <= 1'b1;
              data_mem_addr_o  <= {req_addr_i[ADDR_W-1:LB], LB'(0)};
              data_mem_be_o    <= be_c;
              data_mem_wdata_o <= req_store_i ? wdata_c : '0;
              data_mem_wen_o   <= req_store_i;
              ld_size          <= size_eff;
              ld_lane          <= lane;
              ld_unsigned      <= req_unsigned_i;
              ld_rd            <= req_rd_i;
            end
          end
        end
        REQ: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (data_mem_grnt_i) begin
            data_mem_req_o <= 1'b0;
            state          <= data_mem_wen_o ? IDLE : WAIT;
          end else if (tc_hit) begin
            data_mem_req_o <= 1'b0;
            state          <= IDLE;
            exc_o          <= 1'b1;
            exc_cause_o    <= BUS_TIMEOUT;
          end
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (data_mem_rvalid_i) begin
            state      <= IDLE;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= ld_rd;
            wb_data_o  <= rdata_c;
          end else if (tc_hit) begin
            state       <= IDLE;
            exc_o       <= 1'b1;
            exc_cause_o <= BUS_TIMEOUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed cases plus randomized transactions against a reference model.
module tb_core_lsu;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int TO     = 8;
  localparam int WIN    = 30;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_o;
  logic [1:0]  exc_cause_o;
  logic        data_mem_req_o;
  logic        data_mem_grnt_i = 1'b0;
  logic [31:0] data_mem_addr_o;
  logic [31:0] data_mem_wdata_o;
  logic [3:0]  data_mem_be_o;
  logic        data_mem_wen_o;
  logic [31:0] data_mem_rdata_i = '0;
  logic        data_mem_rvalid_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  core_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .data_mem_req_o(data_mem_req_o), .data_mem_grnt_i(data_mem_grnt_i),
    .data_mem_addr_o(data_mem_addr_o), .data_mem_wdata_o(data_mem_wdata_o),
    .data_mem_be_o(data_mem_be_o), .data_mem_wen_o(data_mem_wen_o),
    .data_mem_rdata_i(data_mem_rdata_i), .data_mem_rvalid_i(data_mem_rvalid_i)
  );

  typedef struct {
    int          req_cnt;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wen;
    bit          stable;
    bit          ready_ok;
    int          wb_cnt;
    int          wb_cyc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    int          exc_cnt;
    int          exc_cyc;
    logic [1:0]  exc_cause;
    logic        ready_end;
  } obs_t;

  typedef struct {
    int          req_cnt;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wb_cnt;
    int          wb_cyc;
    logic [31:0] wb_data;
    int          exc_cnt;
    int          exc_cyc;
    logic [1:0]  exc_cause;
  } exp_t;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Accepts one request in cycle 0 and then plays the bus for a fixed window of cycles.
  // Grant comes in the (gdly+1)-th request cycle, rvalid rdly cycles after the WAIT entry.
  task automatic run_txn(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gdly, input int rdly, output obs_t o);
    int  gcnt;
    int  wcnt;
    bit  granted;
    bit  cap;
    o = '{default: '0};
    o.stable = 1'b1;
    o.ready_ok = 1'b1;
    gcnt = 0; wcnt = 0; granted = 1'b0; cap = 1'b0;
    req_valid_i = 1'b1; req_store_i = st; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    step();
    req_valid_i = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      data_mem_grnt_i = 1'b0;
      data_mem_rvalid_i = 1'b0;
      data_mem_rdata_i = $urandom;
      if (data_mem_req_o) begin
        o.req_cnt++;
        if (req_ready_o) o.ready_ok = 1'b0;
        if (!cap) begin
          cap = 1'b1;
          o.addr = data_mem_addr_o; o.be = data_mem_be_o;
          o.wdata = data_mem_wdata_o; o.wen = data_mem_wen_o;
        end else if (o.addr !== data_mem_addr_o || o.be !== data_mem_be_o ||
                     o.wdata !== data_mem_wdata_o || o.wen !== data_mem_wen_o) begin
          o.stable = 1'b0;
        end
        if (gcnt == gdly) begin
          data_mem_grnt_i = 1'b1;
          granted = 1'b1;
        end
        gcnt++;
      end else if (granted && !st) begin
        if (wcnt == rdly) begin
          data_mem_rvalid_i = 1'b1;
          data_mem_rdata_i = rdata;
        end
        wcnt++;
      end
      if (wb_valid_o) begin
        o.wb_cnt++; o.wb_cyc = c; o.wb_data = wb_data_o; o.wb_rd = wb_rd_o;
      end
      if (exc_o) begin
        o.exc_cnt++; o.exc_cyc = c; o.exc_cause = exc_cause_o;
      end
      step();
    end
    data_mem_grnt_i = 1'b0;
    data_mem_rvalid_i = 1'b0;
    o.ready_end = req_ready_o;
  endtask

  // Reference model from the architectural rules: byte offsets, masks, cycle budget.
  task automatic model(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int gdly,
                       input int rdly, output exp_t e);
    int nb, off, eff, g, r, dl;
    bit trap;
    logic [63:0] wide;
    logic [31:0] m, v;
    e = '{default: '0};
    nb  = 1 << sz;
    off = addr % 4;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (off % nb) != 0;
`else
    trap = 1'b0;
`endif
    eff = off - (off % nb);
    e.addr = addr - off;
    e.be = 4'((((1 << nb) - 1) << eff) & 15);
    wide = {32'h0, wdata} << (8 * eff);
    e.wdata = wide[31:0];
    m = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
    v = (rdata >> (8 * eff)) & m;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~m;
    e.wb_data = v;
    g = gdly + 1;
    if (trap) begin
      e.exc_cnt = 1; e.exc_cyc = 1; e.exc_cause = 2'd1;
    end else if (g > TO) begin
      e.req_cnt = TO; e.exc_cnt = 1; e.exc_cyc = TO + 1; e.exc_cause = 2'd2;
    end else begin
      e.req_cnt = g;
      if (!st) begin
        r  = g + 1 + rdly;
        dl = (TO > g + 1) ? TO : g + 1;
        if (r <= dl) begin
          e.wb_cnt = 1; e.wb_cyc = r + 1;
        end else begin
          e.exc_cnt = 1; e.exc_cyc = dl + 1; e.exc_cause = 2'd2;
        end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", req_ready_o); end
    checks++; if ({wb_valid_o, exc_o, data_mem_req_o, data_mem_wen_o} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %0h expected 0", {wb_valid_o, exc_o, data_mem_req_o, data_mem_wen_o}); end
    checks++; if ({data_mem_addr_o, data_mem_wdata_o, data_mem_be_o, wb_data_o, wb_rd_o, exc_cause_o} !== '0) begin errors++; $display("FAIL reset_data: outputs not all zero"); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
    step();
    checks++; if (req_ready_o !== 1'b1 || data_mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%0h req=%0h expected 1/0", req_ready_o, data_mem_req_o); end
  endtask

  task automatic test_load_word();
    obs_t o;
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 0, o);
    checks++; if (o.wb_cnt !== 1) begin errors++; $display("FAIL lw_wb_count: got %0d expected 1", o.wb_cnt); end
    checks++; if (o.wb_cyc !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", o.wb_cyc); end
    checks++; if (o.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %0h expected deadbeef", o.wb_data); end
    checks++; if (o.wb_rd !== 5'd7) begin errors++; $display("FAIL lw_rd: got %0d expected 7", o.wb_rd); end
    checks++; if (o.addr !== 32'h100 || o.be !== 4'hF || o.wen !== 1'b0) begin errors++; $display("FAIL lw_bus: got addr=%0h be=%0h wen=%0h expected 100/f/0", o.addr, o.be, o.wen); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd3, 32'h80AABBCC, 0, 0, o);
    checks++; if (o.wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %0h expected ffffff80", o.wb_data); end
    checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %0h expected 8", o.be); end
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd3, 32'h80AABBCC, 0, 0, o);
    checks++; if (o.wb_data !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned: got %0h expected 80", o.wb_data); end
  endtask

  task automatic test_store_half();
    obs_t o;
    run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 5'd0, 32'h0, 3, 0, o);
    checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %0h expected c", o.be); end
    checks++; if (o.wdata !== 32'h12340000) begin errors++; $display("FAIL sh_wdata: got %0h expected 12340000", o.wdata); end
    checks++; if (o.req_cnt !== 4) begin errors++; $display("FAIL sh_req_held: got %0d expected 4", o.req_cnt); end
    checks++; if (o.stable !== 1'b1 || o.ready_ok !== 1'b1) begin errors++; $display("FAIL sh_stable_ready: got stable=%0h ready_ok=%0h expected 1/1", o.stable, o.ready_ok); end
    checks++; if (o.wb_cnt !== 0 || o.wen !== 1'b1) begin errors++; $display("FAIL sh_no_wb: got wb=%0d wen=%0h expected 0/1", o.wb_cnt, o.wen); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd1, 32'h0, 0, 999, o);
    checks++; if (o.exc_cnt !== 1 || o.exc_cause !== 2'd2) begin errors++; $display("FAIL to_wait_exc: got cnt=%0d cause=%0d expected 1/2", o.exc_cnt, o.exc_cause); end
    checks++; if (o.exc_cyc !== TO + 1) begin errors++; $display("FAIL to_wait_cycle: got %0d expected %0d", o.exc_cyc, TO + 1); end
    checks++; if (o.wb_cnt !== 0 || o.ready_end !== 1'b1) begin errors++; $display("FAIL to_wait_idle: got wb=%0d ready=%0h expected 0/1", o.wb_cnt, o.ready_end); end
    run_txn(1'b1, 2'd2, 1'b0, 32'h204, 32'h55, 5'd0, 32'h0, 999, 0, o);
    checks++; if (o.req_cnt !== TO || o.exc_cyc !== TO + 1) begin errors++; $display("FAIL to_req: got req=%0d exc_cyc=%0d expected %0d/%0d", o.req_cnt, o.exc_cyc, TO, TO + 1); end
    // Grant on the last budget cycle wins over the timeout.
    run_txn(1'b1, 2'd2, 1'b0, 32'h208, 32'h66, 5'd0, 32'h0, TO - 1, 0, o);
    checks++; if (o.exc_cnt !== 0 || o.req_cnt !== TO) begin errors++; $display("FAIL grant_vs_timeout: got exc=%0d req=%0d expected 0/%0d", o.exc_cnt, o.req_cnt, TO); end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd9, 32'hCAFEF00D, 0, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (o.exc_cnt !== 1 || o.exc_cause !== 2'd1 || o.exc_cyc !== 1) begin errors++; $display("FAIL mis_trap: got cnt=%0d cause=%0d cyc=%0d expected 1/1/1", o.exc_cnt, o.exc_cause, o.exc_cyc); end
    checks++; if (o.req_cnt !== 0 || o.wb_cnt !== 0) begin errors++; $display("FAIL mis_no_bus: got req=%0d wb=%0d expected 0/0", o.req_cnt, o.wb_cnt); end
`else
    checks++; if (o.addr !== 32'h100 || o.exc_cnt !== 0) begin errors++; $display("FAIL mis_align: got addr=%0h exc=%0d expected 100/0", o.addr, o.exc_cnt); end
    checks++; if (o.wb_cnt !== 1 || o.wb_data !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_complete: got wb=%0d data=%0h expected 1/cafef00d", o.wb_cnt, o.wb_data); end
`endif
  endtask

  task automatic test_rvalid_idle();
    data_mem_rvalid_i = 1'b1;
    data_mem_rdata_i = 32'h12345678;
    step();
    data_mem_rvalid_i = 1'b0;
    step();
    checks++; if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL rvalid_idle: got wb=%0h ready=%0h expected 0/1", wb_valid_o, req_ready_o); end
  endtask

  task automatic test_reset_in_wait();
    int wbs;
    int excs;
    req_valid_i = 1'b1; req_store_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h300; req_rd_i = 5'd5;
    step();
    req_valid_i = 1'b0;
    data_mem_grnt_i = 1'b1;
    step();
    data_mem_grnt_i = 1'b0;
    checks++; if (req_ready_o !== 1'b0 || data_mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_wait_setup: got ready=%0h req=%0h expected 0/0", req_ready_o, data_mem_req_o); end
    #2 arst_ni = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1 || {data_mem_addr_o, data_mem_be_o, wb_valid_o, exc_o} !== '0) begin errors++; $display("FAIL rst_wait_outputs: got ready=%0h addr=%0h be=%0h", req_ready_o, data_mem_addr_o, data_mem_be_o); end
    @(negedge clk_i);
    arst_ni = 1'b1;
    step();
    data_mem_rvalid_i = 1'b1;
    data_mem_rdata_i = 32'hABCD0123;
    wbs = 0; excs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      data_mem_rvalid_i = 1'b0;
      if (wb_valid_o) wbs++;
      if (exc_o) excs++;
    end
    checks++; if (wbs !== 0 || excs !== 0) begin errors++; $display("FAIL rst_wait_late_rvalid: got wb=%0d exc=%0d expected 0/0", wbs, excs); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit st, uns;
    logic [1:0] sz;
    logic [31:0] addr, wdata, rdata;
    logic [4:0] rd;
    int gdly, rdly;
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2));
      addr = $urandom; wdata = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      gdly = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
      rdly = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      model(st, sz, uns, addr, wdata, rdata, gdly, rdly, e);
      run_txn(st, sz, uns, addr, wdata, rd, rdata, gdly, rdly, o);
      checks++; if (o.req_cnt !== e.req_cnt) begin errors++; $display("FAIL rnd%0d_req_cnt: got %0d expected %0d", n, o.req_cnt, e.req_cnt); end
      if (e.req_cnt > 0) begin
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL rnd%0d_addr: got %0h expected %0h", n, o.addr, e.addr); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL rnd%0d_be: got %0h expected %0h", n, o.be, e.be); end
        checks++; if (o.wen !== st) begin errors++; $display("FAIL rnd%0d_wen: got %0h expected %0h", n, o.wen, st); end
        checks++; if (o.stable !== 1'b1 || o.ready_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable_ready: got %0h/%0h expected 1/1", n, o.stable, o.ready_ok); end
        if (st) begin
          checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rnd%0d_wdata: got %0h expected %0h", n, o.wdata, e.wdata); end
        end
      end
      checks++; if (o.wb_cnt !== e.wb_cnt) begin errors++; $display("FAIL rnd%0d_wb_cnt: got %0d expected %0d", n, o.wb_cnt, e.wb_cnt); end
      if (e.wb_cnt == 1) begin
        checks++; if (o.wb_cyc !== e.wb_cyc) begin errors++; $display("FAIL rnd%0d_wb_cyc: got %0d expected %0d", n, o.wb_cyc, e.wb_cyc); end
        checks++; if (o.wb_data !== e.wb_data || o.wb_rd !== rd) begin errors++; $display("FAIL rnd%0d_wb: got %0h rd%0d expected %0h rd%0d", n, o.wb_data, o.wb_rd, e.wb_data, rd); end
      end
      checks++; if (o.exc_cnt !== e.exc_cnt) begin errors++; $display("FAIL rnd%0d_exc_cnt: got %0d expected %0d", n, o.exc_cnt, e.exc_cnt); end
      if (e.exc_cnt == 1) begin
        checks++; if (o.exc_cyc !== e.exc_cyc || o.exc_cause !== e.exc_cause) begin errors++; $display("FAIL rnd%0d_exc: got cyc%0d cause%0d expected cyc%0d cause%0d", n, o.exc_cyc, o.exc_cause, e.exc_cyc, e.exc_cause); end
      end
      checks++; if (o.ready_end !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_end: got %0h expected 1", n, o.ready_end); end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_misalign();
    test_rvalid_idle();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
